// File: rtl/add_share_arbiter_pkg.sv
// Shared definitions for the add_share_arbiter slice.
package add_share_arbiter_pkg;

    // Datapath width of the shared adder. Signed overflow occurs when both
    // operands have the same sign and the sum's sign differs from it.
    localparam int unsigned WORD_W = 64;

    // Response slot occupancy.
    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_e;

endpackage

// File: rtl/add_64bit.sv
// 64-bit signed adder with overflow flag.
module add_64bit (
    input  logic [63:0] a,
    input  logic [63:0] b,
    output logic [63:0] sum,
    output logic        overflow
);

    // Wrap-around sum; overflow when same-signed operands yield an opposite-signed sum.
    always_comb begin
        sum      = a + b;
        overflow = (a[63] == b[63]) && (sum[63] != a[63]);
    end

endmodule

// File: rtl/add_share_arbiter_rr_grant.sv
// Combinational round-robin grant: first valid request at or above ptr, modulo NREQ.
module rr_grant #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned ID_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [ID_W-1:0] ptr,
    output logic [NREQ-1:0] grant,
    output logic [ID_W-1:0] gidx,
    output logic            any
);

    logic [2*NREQ-1:0] dbl;
    logic [NREQ-1:0]   rot;
    int unsigned       pos;

    // Rotate requests so ptr lands at bit 0, then take the lowest set bit.
    always_comb begin
        dbl   = {req, req} >> ptr;
        rot   = dbl[NREQ-1:0];
        pos   = 0;
        gidx  = '0;
        any   = 1'b0;
        grant = '0;
        for (int unsigned j = 0; j < NREQ; j++) begin
            if (!any && rot[j]) begin
                any = 1'b1;
                pos = 32'(ptr) + j;
                if (pos >= NREQ) begin
                    pos = pos - NREQ;
                end
                gidx = pos[ID_W-1:0];
            end
        end
        for (int unsigned i = 0; i < NREQ; i++) begin
            grant[i] = any && (32'(gidx) == i);
        end
    end

endmodule

// File: rtl/add_share_arbiter.sv
// Round-robin sharing of one add_64bit among NREQ requesters with a single
// registered response slot under valid/ready backpressure.
module add_share_arbiter
    import add_share_arbiter_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    parameter int unsigned ID_W = $clog2(NREQ)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [NREQ*WORD_W-1:0] req_a,
    input  logic [NREQ*WORD_W-1:0] req_b,
    output logic                   resp_valid,
    input  logic                   resp_ready,
    output logic [WORD_W-1:0]      resp_sum,
    output logic                   resp_overflow,
    output logic [ID_W-1:0]        resp_id
);

    slot_e             slot_q, slot_d;
    logic [NREQ-1:0]   grant;
    logic [ID_W-1:0]   gidx;
    logic              any;
    logic [ID_W-1:0]   ptr_q, ptr_nxt;
    logic              can_accept, accept;
    logic [WORD_W-1:0] op_a, op_b, add_sum;
    logic              add_ovf;

    rr_grant #(
        .NREQ (NREQ),
        .ID_W (ID_W)
    ) u_grant (
        .req   (req_valid),
        .ptr   (ptr_q),
        .grant (grant),
        .gidx  (gidx),
        .any   (any)
    );

    add_64bit u_add (
        .a        (op_a),
        .b        (op_b),
        .sum      (add_sum),
        .overflow (add_ovf)
    );

    // Handshake: accept only when the slot is empty or draining, never in reset.
    always_comb begin
        resp_valid = (slot_q == SLOT_FULL);
        can_accept = !resp_valid || resp_ready;
        req_ready  = (rst_n && can_accept) ? grant : '0;
        accept     = rst_n && can_accept && any;
    end

    // Operand mux for the granted requester and wrap-around pointer advance.
    always_comb begin
        op_a = '0;
        op_b = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (32'(gidx) == i) begin
                op_a = req_a[i*WORD_W +: WORD_W];
                op_b = req_b[i*WORD_W +: WORD_W];
            end
        end
        if (32'(gidx) == NREQ - 1) begin
            ptr_nxt = '0;
        end else begin
            ptr_nxt = gidx + 1'b1;
        end
    end

    // Slot next-state: fill on accept, empty on drain without accept.
    always_comb begin
        slot_d = slot_q;
        if (accept) begin
            slot_d = SLOT_FULL;
        end else if (resp_valid && resp_ready) begin
            slot_d = SLOT_EMPTY;
        end
    end

    // Slot state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            slot_q <= SLOT_EMPTY;
        end else begin
            slot_q <= slot_d;
        end
    end

    // Response data and pointer load only on accept; they hold across drains.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            resp_sum      <= '0;
            resp_overflow <= 1'b0;
            resp_id       <= '0;
            ptr_q         <= '0;
        end else if (accept) begin
            resp_sum      <= add_sum;
            resp_overflow <= add_ovf;
            resp_id       <= gidx;
            ptr_q         <= ptr_nxt;
        end
    end

endmodule

// File: tb/tb_add_share_arbiter.sv
// Scoreboard bench for add_share_arbiter: directed scenarios plus random traffic.
module tb_add_share_arbiter;
    import add_share_arbiter_pkg::*;

    localparam int unsigned NREQ = 4;
    localparam int unsigned ID_W = 2;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic [NREQ-1:0]        req_valid;
    logic [NREQ-1:0]        req_ready;
    logic [NREQ*WORD_W-1:0] req_a, req_b;
    logic                   resp_valid;
    logic                   resp_ready = 1'b0;
    logic [WORD_W-1:0]      resp_sum;
    logic                   resp_overflow;
    logic [ID_W-1:0]        resp_id;

    logic        tb_valid [NREQ];
    logic [63:0] tb_a     [NREQ];
    logic [63:0] tb_b     [NREQ];

    typedef struct {
        logic [63:0] sum;
        logic        ovf;
        int          id;
    } exp_t;

    exp_t exp_q[$];
    int   m_ptr = 0;
    bit   m_full = 0;
    int   passed = 0;
    int   total = 0;
    int   opk = 0;

    add_share_arbiter #(
        .NREQ (NREQ)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_a         (req_a),
        .req_b         (req_b),
        .resp_valid    (resp_valid),
        .resp_ready    (resp_ready),
        .resp_sum      (resp_sum),
        .resp_overflow (resp_overflow),
        .resp_id       (resp_id)
    );

    always #5 clk = ~clk;

    // Pack per-requester bench variables onto the DUT buses.
    always_comb begin
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_valid[i]         = tb_valid[i];
            req_a[i*64 +: 64]    = tb_a[i];
            req_b[i*64 +: 64]    = tb_b[i];
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask

    // Reference: exact signed sum; overflow when it does not fit in 64 signed bits.
    function automatic exp_t model(input logic [63:0] a, input logic [63:0] b, input int id);
        exp_t e;
        logic signed [64:0] w;
        w = $signed({a[63], a}) + $signed({b[63], b});
        e.sum = w[63:0];
        e.ovf = (w > 65'sh0_7FFF_FFFF_FFFF_FFFF) || (w < -65'sh0_8000_0000_0000_0000);
        e.id  = id;
        return e;
    endfunction

    // One clock: predict the grant from the bench's own ptr/occupancy, check, advance.
    task automatic step();
        int g;
        logic [NREQ-1:0] er;
        bit can;
        g = -1;
        @(negedge clk);
        if (!rst_n) begin
            chk("req_ready_in_reset", req_ready, '0);
            m_full = 0;
            m_ptr  = 0;
            exp_q.delete();
        end else begin
            chk("resp_valid", resp_valid, m_full);
            can = !m_full || resp_ready;
            for (int k = 0; k < NREQ; k++)
                if (g < 0 && tb_valid[(m_ptr + k) % NREQ]) g = (m_ptr + k) % NREQ;
            er = '0;
            if (g >= 0 && can) er[g] = 1'b1;
            chk("req_ready", req_ready, er);
            if (g >= 0 && can) begin
                exp_q.push_back(model(tb_a[g], tb_b[g], g));
                m_ptr  = (g + 1) % NREQ;
                m_full = 1;
            end else begin
                g = -1;
                if (m_full && resp_ready) m_full = 0;
            end
        end
        @(posedge clk);
        #1;
        if (g >= 0) tb_valid[g] = 1'b0;
    endtask

    task automatic set_req(input int i, input logic [63:0] a, input logic [63:0] b);
        tb_valid[i] = 1'b1;
        tb_a[i]     = a;
        tb_b[i]     = b;
    endtask

    task automatic clear_all();
        for (int i = 0; i < NREQ; i++) tb_valid[i] = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_sum", resp_sum, 0);
        chk("rst_resp_overflow", resp_overflow, 0);
        chk("rst_resp_id", resp_id, 0);
        rst_n = 1'b1;
    endtask

    // Fill any idle requester (so all stay valid) with a = k, b = 10k.
    task automatic fill_all_counting();
        for (int i = 0; i < NREQ; i++)
            if (!tb_valid[i]) begin
                opk++;
                set_req(i, 64'(opk), 64'(10 * opk));
            end
    endtask

    function automatic logic [63:0] rnd64();
        case ($urandom % 5)
            0: return 64'h7FFF_FFFF_FFFF_FFFF;
            1: return 64'h8000_0000_0000_0000;
            2: return 64'(int'($urandom % 9) - 4);
            default: return {$urandom, $urandom};
        endcase
    endfunction

    // Monitor: pop and compare on every handshake; a stalled slot must not change.
    bit          stall = 0;
    logic [63:0] h_sum;
    logic        h_ovf;
    logic [ID_W-1:0] h_id;
    exp_t        e;
    always @(negedge clk) begin
        if (!rst_n) begin
            stall = 0;
        end else begin
            if (stall) begin
                chk("stall_valid", resp_valid, 1);
                chk("stall_sum", resp_sum, h_sum);
                chk("stall_ovf", resp_overflow, h_ovf);
                chk("stall_id", resp_id, h_id);
            end
            if (resp_valid && resp_ready) begin
                if (exp_q.size() == 0) begin
                    chk("resp_without_request", resp_valid, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("resp_sum", resp_sum, e.sum);
                    chk("resp_overflow", resp_overflow, e.ovf);
                    chk("resp_id", resp_id, 64'(e.id));
                end
            end
            stall = resp_valid && !resp_ready;
            h_sum = resp_sum;
            h_ovf = resp_overflow;
            h_id  = resp_id;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < NREQ; i++) begin
            tb_valid[i] = 1'b0;
            tb_a[i]     = '0;
            tb_b[i]     = '0;
        end
        @(posedge clk);
        #1;
        do_reset();

        // Basic add on requester 0.
        resp_ready = 1'b1;
        set_req(0, 64'd1, 64'd2);
        step();
        step();

        // Signed overflow on requester 2.
        set_req(2, 64'h7FFF_FFFF_FFFF_FFFF, 64'd2);
        step();
        step();

        // All four valid: 0,1,2,3,0,1,2,3 at one result per cycle.
        do_reset();
        resp_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            fill_all_counting();
            step();
        end

        // Backpressure for three cycles, then drain and accept in the same cycle.
        resp_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            fill_all_counting();
            step();
        end
        resp_ready = 1'b1;
        fill_all_counting();
        step();
        clear_all();
        step();

        // Reset while full with id 3 and ptr 0; next grant must go to requester 0.
        do_reset();
        resp_ready = 1'b0;
        set_req(3, 64'd5, 64'd6);
        step();
        clear_all();
        do_reset();
        resp_ready = 1'b1;
        fill_all_counting();
        step();
        clear_all();
        step();

        // Only requester 1 valid after ptr reaches 2: granted every cycle.
        do_reset();
        resp_ready = 1'b1;
        set_req(1, 64'd100, 64'd1);
        step();
        for (int c = 0; c < 4; c++) begin
            set_req(1, 64'(200 + c), 64'hFFFF_FFFF_FFFF_FFFF);
            step();
        end
        step();

        // Random traffic with random backpressure.
        for (int c = 0; c < 400; c++) begin
            resp_ready = ($urandom % 4) != 0;
            for (int i = 0; i < NREQ; i++)
                if (!tb_valid[i] && ($urandom % 2) == 0) set_req(i, rnd64(), rnd64());
            step();
        end

        // Drain everything outstanding.
        resp_ready = 1'b1;
        for (int c = 0; c < 12; c++) step();
        clear_all();
        for (int c = 0; c < 3; c++) step();
        chk("scoreboard_empty", 64'(exp_q.size()), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
